// File: rtl/gcn_batch_scheduler_if.sv
// gcn_batch_scheduler_if: host command, GCN core and result-port signals of the batch scheduler
interface gcn_batch_scheduler_if #(
  parameter int NUM_GRAPHS_MAX = 16,
  parameter int ADDRESS_WIDTH = 13,
  parameter int COO_BW = 3,
  parameter int FEATURE_ROWS = 6,
  parameter int MAX_ADDRESS_WIDTH = 2
);
  localparam int GRAPH_CNT_W = $clog2(NUM_GRAPHS_MAX);
  localparam int LEN_W = $clog2(NUM_GRAPHS_MAX + 1);
  localparam int MEM_AW = ADDRESS_WIDTH + GRAPH_CNT_W;
  logic batch_start;
  logic [LEN_W-1:0] batch_len;
  logic core_clear;
  logic core_start;
  logic core_done;
  logic [ADDRESS_WIDTH-1:0] core_read_address;
  logic core_enable_read;
  logic [COO_BW-1:0] core_coo_address;
  logic [MAX_ADDRESS_WIDTH-1:0] core_max_addi_answer [0:FEATURE_ROWS-1];
  logic [MEM_AW-1:0] mem_read_address;
  logic mem_read_enable;
  logic [GRAPH_CNT_W+COO_BW-1:0] coo_mem_address;
  logic res_valid;
  logic res_ready;
  logic [GRAPH_CNT_W-1:0] res_graph;
  logic [FEATURE_ROWS*MAX_ADDRESS_WIDTH-1:0] res_data;
  logic busy;
  logic batch_done;
  logic timeout_err;
  modport master (
    input batch_start, batch_len, core_done, core_read_address, core_enable_read,
          core_coo_address, core_max_addi_answer, res_ready,
    output core_clear, core_start, mem_read_address, mem_read_enable, coo_mem_address,
           res_valid, res_graph, res_data, busy, batch_done, timeout_err
  );
  modport slave (
    output batch_start, batch_len, core_done, core_read_address, core_enable_read,
           core_coo_address, core_max_addi_answer, res_ready,
    input core_clear, core_start, mem_read_address, mem_read_enable, coo_mem_address,
          res_valid, res_graph, res_data, busy, batch_done, timeout_err
  );
endinterface

// File: rtl/gcn_batch_scheduler.sv
// gcn_batch_scheduler: runs a batch of graphs through one GCN core, relocating its memories per graph
module gcn_batch_scheduler #(
  parameter int NUM_GRAPHS_MAX = 16,
  parameter int ADDRESS_WIDTH = 13,
  parameter int FM_BASE_STRIDE = 512,
  parameter int COO_BW = 3,
  parameter int FEATURE_ROWS = 6,
  parameter int MAX_ADDRESS_WIDTH = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clk,
  input logic reset,
  gcn_batch_scheduler_if.master bus
);
  localparam int GRAPH_CNT_W = $clog2(NUM_GRAPHS_MAX);
  localparam int LEN_W = $clog2(NUM_GRAPHS_MAX + 1);
  localparam int MEM_AW = ADDRESS_WIDTH + GRAPH_CNT_W;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, LAUNCH = 3'd2, RUN = 3'd3, OUT = 3'd4, FINISH = 3'd5;
  logic [2:0] state;
  logic [GRAPH_CNT_W-1:0] graph_idx;
  logic [LEN_W-1:0] len;
  logic [TO_W-1:0] to_cnt;
  logic done_q;
  logic timeout_err;
  logic [GRAPH_CNT_W-1:0] res_graph;
  logic [FEATURE_ROWS*MAX_ADDRESS_WIDTH-1:0] res_data;
  logic done_edge;
  assign done_edge = bus.core_done & ~done_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      graph_idx <= '0;
      len <= '0;
      to_cnt <= '0;
      done_q <= 1'b0;
      timeout_err <= 1'b0;
      res_graph <= '0;
      res_data <= '0;
    end else begin
      done_q <= bus.core_done;
      case (state)
        IDLE: if (bus.batch_start) begin
          timeout_err <= 1'b0;
          graph_idx <= '0;
          len <= (bus.batch_len > LEN_W'(NUM_GRAPHS_MAX)) ? LEN_W'(NUM_GRAPHS_MAX) : bus.batch_len;
          state <= (bus.batch_len == '0) ? FINISH : CLEAR;
        end
        CLEAR: state <= LAUNCH;
        LAUNCH: begin
          to_cnt <= '0;
          state <= RUN;
        end
        RUN: if (done_edge) begin
          for (int i = 0; i < FEATURE_ROWS; i++)
            res_data[i*MAX_ADDRESS_WIDTH +: MAX_ADDRESS_WIDTH] <= bus.core_max_addi_answer[i];
          res_graph <= graph_idx;
          state <= OUT;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err <= 1'b1;
          state <= FINISH;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
        OUT: if (bus.res_ready) begin
          if (LEN_W'(graph_idx) + LEN_W'(1) == len) state <= FINISH;
          else begin
            graph_idx <= graph_idx + 1'b1;
            state <= CLEAR;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // an aborted batch reaches FINISH with timeout_err set, which doubles as the abort clear
  assign bus.core_clear = (state == CLEAR) | ((state == FINISH) & timeout_err);
  assign bus.core_start = state == LAUNCH;
  assign bus.res_valid = state == OUT;
  assign bus.batch_done = state == FINISH;
  assign bus.busy = state != IDLE;
  assign bus.timeout_err = timeout_err;
  assign bus.res_graph = res_graph;
  assign bus.res_data = res_data;
  assign bus.mem_read_enable = bus.core_enable_read & (state == RUN);
  assign bus.mem_read_address = MEM_AW'(graph_idx) * MEM_AW'(FM_BASE_STRIDE) + MEM_AW'(bus.core_read_address);
  assign bus.coo_mem_address = {graph_idx, bus.core_coo_address[COO_BW-1:0]};
endmodule

// File: tb/tb_gcn_batch_scheduler.sv
// tb_gcn_batch_scheduler: directed batches against a randomized core model and result scoreboard
module tb_gcn_batch_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  gcn_batch_scheduler_if #(.NUM_GRAPHS_MAX(16), .ADDRESS_WIDTH(13), .COO_BW(3), .FEATURE_ROWS(6),
    .MAX_ADDRESS_WIDTH(2)) bus();
  gcn_batch_scheduler #(.NUM_GRAPHS_MAX(16), .ADDRESS_WIDTH(13), .FM_BASE_STRIDE(512), .COO_BW(3),
    .FEATURE_ROWS(6), .MAX_ADDRESS_WIDTH(2), .TIMEOUT_CYCLES(64)) dut (.clk(clk), .reset(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  int lat = 0;
  int dcnt = 0;
  int cyc = 0;
  int n_start = 0, n_bstart = 0, n_clear = 0, n_bdone = 0, n_valid = 0;
  int start_cyc = 0, done_cyc = 0, valid_cyc = 0, hs_cyc = 0, bdone_cyc = 0;
  logic valid_q = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [11:0] ans;
  // core model plus monitor: answers each launch with a random argmax vector after lat cycles
  initial begin
    bus.core_done = 1'b0;
    for (int i = 0; i < 6; i++) bus.core_max_addi_answer[i] = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.core_start) begin
        n_start++;
        start_cyc = cyc;
        for (int i = 0; i < 6; i++) begin
          ans[i*2 +: 2] = 2'($urandom);
          bus.core_max_addi_answer[i] = ans[i*2 +: 2];
        end
        exp_q.push_back({4'(n_bstart), ans});
        n_bstart++;
        dcnt = lat;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          bus.core_done = 1'b1;
          done_cyc = cyc;
        end
      end else begin
        bus.core_done = 1'b0;
      end
      if (bus.core_clear) n_clear++;
      if (bus.batch_done) begin
        n_bdone++;
        bdone_cyc = cyc;
      end
      if (bus.res_valid) n_valid++;
      if (bus.res_valid && !valid_q) valid_cyc = cyc;
      valid_q = bus.res_valid;
      if (bus.res_valid && bus.res_ready) begin
        got_q.push_back({bus.res_graph, bus.res_data});
        hs_cyc = cyc;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start_batch(input int n, input int l);
    exp_q.delete();
    got_q.delete();
    n_start = 0; n_bstart = 0; n_clear = 0; n_bdone = 0; n_valid = 0;
    lat = l;
    bus.batch_len = 5'(n);
    bus.batch_start = 1'b1;
    step();
    bus.batch_start = 1'b0;
  endtask
  task automatic wait_bdone(input int budget, input string tag);
    int k = 0;
    while (n_bdone == 0 && k < budget) begin step(); k++; end
    check(tag, 32'(n_bdone != 0), 1);
  endtask
  task automatic wait_starts(input int n, input int budget, input string tag);
    int k = 0;
    while (n_start < n && k < budget) begin step(); k++; end
    check(tag, 32'(n_start >= n), 1);
  endtask
  task automatic compare_results(input int n, input string tag);
    check({tag, "_cnt"}, got_q.size(), n);
    while (got_q.size() > 0 && exp_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
  endtask
  initial begin
    int a;
    int k;
    bus.batch_start = 1'b0;
    bus.batch_len = '0;
    bus.core_read_address = '0;
    bus.core_enable_read = 1'b0;
    bus.core_coo_address = '0;
    bus.res_ready = 1'b1;
    repeat (3) step();
    check("rst_busy", bus.busy, 0);
    check("rst_ctl", {bus.core_clear, bus.core_start, bus.res_valid, bus.batch_done, bus.timeout_err}, 0);
    check("rst_res", {bus.res_graph, bus.res_data}, 0);
    check("rst_mem", {bus.mem_read_address, bus.coo_mem_address, bus.mem_read_enable}, 0);
    rst_n = 1'b1;
    step();
    // three graphs, done 20 cycles after each launch
    start_batch(3, 20);
    check("lat_clear", {bus.core_clear, bus.core_start, bus.busy}, 3'b101);
    step();
    check("lat_start", {bus.core_clear, bus.core_start}, 2'b01);
    wait_bdone(300, "b3_wait");
    check("b3_idle", bus.busy, 0);
    check("b3_res_lat", valid_cyc - done_cyc, 1);
    check("b3_done_lat", bdone_cyc - hs_cyc, 1);
    repeat (3) step();
    check("b3_starts", n_start, 3);
    check("b3_clears", n_clear, 3);
    check("b3_bdone", n_bdone, 1);
    compare_results(3, "b3_res");
    // backpressure on graph 0, then relocation while graph 1 runs
    bus.res_ready = 1'b0;
    start_batch(2, 15);
    k = 0;
    while (!bus.res_valid && k < 100) begin step(); k++; end
    check("bp_valid_wait", bus.res_valid, 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", bus.res_valid, 1);
      check("bp_data", {bus.res_graph, bus.res_data}, exp_q[0]);
      check("bp_nostart", n_start, 1);
      step();
    end
    bus.res_ready = 1'b1;
    wait_starts(2, 20, "reloc_wait");
    bus.core_read_address = 13'h005;
    bus.core_enable_read = 1'b1;
    bus.core_coo_address = 3'd4;
    #1;
    check("reloc_addr", bus.mem_read_address, 17'h205);
    check("reloc_coo", bus.coo_mem_address, 7'h0C);
    check("reloc_en", bus.mem_read_enable, 1);
    a = $urandom_range(0, 8191);
    bus.core_read_address = 13'(a);
    #1;
    check("reloc_rand", bus.mem_read_address, 32'(512 + a));
    wait_bdone(100, "bp_wait");
    step();
    check("idle_en_gated", bus.mem_read_enable, 0);
    bus.core_enable_read = 1'b0;
    bus.core_read_address = '0;
    bus.core_coo_address = '0;
    compare_results(2, "bp_res");
    // core never completes
    start_batch(2, 0);
    wait_bdone(200, "to_wait");
    check("to_err", bus.timeout_err, 1);
    check("to_timing", bdone_cyc - start_cyc, 65);
    check("to_starts", n_start, 1);
    check("to_clears", n_clear, 2);
    check("to_novalid", n_valid, 0);
    repeat (3) step();
    check("to_sticky", bus.timeout_err, 1);
    // empty batch
    start_batch(0, 0);
    check("len0_done", {bus.batch_done, bus.busy, bus.core_clear, bus.timeout_err}, 4'b1100);
    step();
    check("len0_idle", {bus.batch_done, bus.busy}, 0);
    check("len0_nostart", n_start, 0);
    // batch_start while busy is ignored
    start_batch(1, 20);
    repeat (5) step();
    bus.batch_len = 5'd5;
    bus.batch_start = 1'b1;
    step();
    bus.batch_start = 1'b0;
    wait_bdone(200, "ign_wait");
    repeat (4) step();
    check("ign_starts", n_start, 1);
    check("ign_bdone", n_bdone, 1);
    compare_results(1, "ign_res");
    // oversize batch is clamped
    start_batch(20, $urandom_range(3, 12));
    wait_bdone(2000, "clamp_wait");
    step();
    check("clamp_starts", n_start, 16);
    compare_results(16, "clamp_res");
    // reset during graph 2
    start_batch(3, 20);
    wait_starts(3, 200, "mid_wait");
    repeat (2) step();
    rst_n = 1'b0;
    dcnt = 0;
    #1;
    check("mid_busy", bus.busy, 0);
    check("mid_ctl", {bus.core_clear, bus.core_start, bus.res_valid, bus.batch_done, bus.timeout_err}, 0);
    check("mid_res", {bus.res_graph, bus.res_data}, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    start_batch(1, 10);
    wait_bdone(100, "post_wait");
    step();
    check("post_starts", n_start, 1);
    compare_results(1, "post_res");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
